muldiv_seq: RTL

//  Multi-cycle sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the exe stage.

---
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiplier and restoring divider with
// sign fix-up, single-cycle done pulse and a held result register.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;

  // Accept-time decode: signedness, magnitudes and the two divide special cases.
  logic             signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_result;

  always_comb begin
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign_a   = signed_a && rs1[WIDTH-1];
    sign_b   = signed_b && rs2[WIDTH-1];
    mag_a    = sign_a ? -rs1 : rs1;
    mag_b    = sign_b ? -rs2 : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
    special_result = '0;
    if (div_zero)     special_result = op[1] ? rs1 : '1;
    else if (div_ovf) special_result = op[1] ? '0 : rs1;
  end

  // One iteration step; the multiplier shifts out of prod_q's low half while the
  // divider shifts the dividend out of it and the quotient bits back in.
  logic [WIDTH:0]     mul_sum, rem_shift, rem_trial;
  logic               quo_bit;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   rem_d;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {rem_q, prod_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opnd_q};
    quo_bit   = ~rem_trial[WIDTH];
    if (op_q[2]) begin
      prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], quo_bit};
      rem_d  = quo_bit ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end else begin
      prod_d = {mul_sum, prod_q[WIDTH-1:1]};
      rem_d  = rem_q;
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_result;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    unique case (op_q)
      3'b000:                 fix_result = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
      default:                fix_result = neg_q ? -rem_q : rem_q;
    endcase
  end

  // NOTE: every register, datapath included, is cleared by the synchronous reset so
  // a mid-operation reset leaves no stale operand or result visible afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            neg_q  <= (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
            opnd_q <= op[2] ? mag_b : mag_a;
            prod_q <= {{WIDTH{1'b0}}, op[2] ? mag_a : mag_b};
            rem_q  <= '0;
            if (div_zero || div_ovf) begin
              result_q <= special_result;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q   <= CW'(WIDTH);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            prod_q <= prod_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = ((state_q == IDLE) && start) || (state_q == CALC) || (state_q == FIX);
  assign done   = done_q;
  assign result = result_q;

endmodule
